// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmem_pkg
// Brief    : Shared defaults and state type for the banked data memory.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    localparam int unsigned c_data_w    = 32;
    localparam int unsigned c_bank_bits = 3;
    localparam int unsigned c_word_bits = 10;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_bank.sv
//------------------------------------------------------------------------------
// Module   : dmem_bank
// Brief    : One memory bank with byte-enabled synchronous write, registered read.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W    = c_data_w,
    parameter int WORD_BITS = c_word_bits
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_we,
    input  logic [DATA_W/8-1:0]    i_be,
    input  logic [WORD_BITS-1:0]   i_addr,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic                   i_re,
    output logic [DATA_W-1:0]      o_rdata
);

    localparam int c_n_bytes = DATA_W / 8;
    localparam int c_depth   = 2 ** WORD_BITS;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rdata_q;
    logic [DATA_W-1:0] w_rdata_d;

    // Storage carries no reset so it can map onto block RAM; the clear sweep
    // in the parent provides the defined initial contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_n_bytes; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rdata_d = r_rdata_q;
        if (i_re) begin
            w_rdata_d = r_mem[i_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata_q <= '0;
        end else begin
            r_rdata_q <= w_rdata_d;
        end
    end

    assign o_rdata = r_rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_banked.sv
//------------------------------------------------------------------------------
// Module   : dmem_banked
// Brief    : Banked data memory with power-up clear sweep and 1-cycle reads.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_banked
    import dmem_pkg::*;
#(
    parameter int DATA_W    = c_data_w,
    parameter int BANK_BITS = c_bank_bits,
    parameter int WORD_BITS = c_word_bits
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           read_write,
    input  logic [BANK_BITS+WORD_BITS-1:0] address,
    input  logic [DATA_W-1:0]              data_in,
    input  logic [DATA_W/8-1:0]            byte_en,
    output logic                           resp_valid,
    output logic [DATA_W-1:0]              dataOut,
    output logic                           init_done
);

    localparam int c_n_banks = 2 ** BANK_BITS;

    state_t                r_state_q, w_state_d;
    logic [WORD_BITS-1:0]  r_cnt_q,   w_cnt_d;
    logic                  r_resp_valid_q, w_resp_valid_d;
    logic [BANK_BITS-1:0]  r_sel_q,   w_sel_d;

    logic [BANK_BITS-1:0]  w_bank;
    logic [WORD_BITS-1:0]  w_word;
    logic                  w_accept;
    logic [WORD_BITS-1:0]  w_mem_addr;
    logic [DATA_W/8-1:0]   w_mem_be;
    logic [DATA_W-1:0]     w_mem_wdata;
    logic                  w_bank_we [c_n_banks];
    logic                  w_bank_re [c_n_banks];
    logic [DATA_W-1:0]     w_bank_rdata [c_n_banks];

    assign w_bank   = address[BANK_BITS+WORD_BITS-1:WORD_BITS];
    assign w_word   = address[WORD_BITS-1:0];
    assign w_accept = req_valid && (r_state_q == ST_READY);

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_resp_valid_d = 1'b0;
        w_sel_d        = r_sel_q;
        w_mem_addr     = w_word;
        w_mem_be       = byte_en;
        w_mem_wdata    = data_in;
        for (int b = 0; b < c_n_banks; b++) begin
            w_bank_we[b] = 1'b0;
            w_bank_re[b] = 1'b0;
        end

        case (r_state_q)
            ST_INIT: begin
                // Every bank clears the same index in parallel.
                w_cnt_d     = r_cnt_q + WORD_BITS'(1);
                w_mem_addr  = r_cnt_q;
                w_mem_be    = '1;
                w_mem_wdata = '0;
                for (int b = 0; b < c_n_banks; b++) begin
                    w_bank_we[b] = 1'b1;
                end
                if (&r_cnt_q) begin
                    w_state_d = ST_READY;
                end
            end
            ST_READY: begin
                for (int b = 0; b < c_n_banks; b++) begin
                    w_bank_we[b] = w_accept &&  read_write && (w_bank == BANK_BITS'(b));
                    w_bank_re[b] = w_accept && !read_write && (w_bank == BANK_BITS'(b));
                end
                if (w_accept && !read_write) begin
                    w_resp_valid_d = 1'b1;
                    w_sel_d        = w_bank;
                end
            end
            default: w_state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q      <= ST_INIT;
            r_cnt_q        <= '0;
            r_resp_valid_q <= 1'b0;
            r_sel_q        <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_sel_q        <= w_sel_d;
        end
    end

    for (genvar g = 0; g < c_n_banks; g++) begin : g_bank
        dmem_bank #(
            .DATA_W    (DATA_W),
            .WORD_BITS (WORD_BITS)
        ) u_bank (
            .clk     (clock),
            .rst     (reset),
            .i_we    (w_bank_we[g]),
            .i_be    (w_mem_be),
            .i_addr  (w_mem_addr),
            .i_wdata (w_mem_wdata),
            .i_re    (w_bank_re[g]),
            .o_rdata (w_bank_rdata[g])
        );
    end

    // Bank read registers and the select only move on reads, so dataOut holds.
    assign dataOut    = w_bank_rdata[r_sel_q];
    assign resp_valid = r_resp_valid_q;
    assign req_ready  = (r_state_q == ST_READY);
    assign init_done  = (r_state_q == ST_READY);

endmodule

`default_nettype wire

// File: tb/tb_dmem_banked.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_banked
// Brief    : Directed self-checking bench for dmem_banked.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_banked;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        read_write;
    logic [12:0] address;
    logic [31:0] data_in;
    logic [3:0]  byte_en;
    logic        resp_valid;
    logic [31:0] dataOut;
    logic        init_done;

    int n_checks = 0;
    int n_errors = 0;

    dmem_banked dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .read_write (read_write),
        .address    (address),
        .data_in    (data_in),
        .byte_en    (byte_en),
        .resp_valid (resp_valid),
        .dataOut    (dataOut),
        .init_done  (init_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input int bank, input int word, input logic [31:0] d, input logic [3:0] be);
        req_valid  = 1'b1;
        read_write = 1'b1;
        address    = {3'(bank), 10'(word)};
        data_in    = d;
        byte_en    = be;
        tick();
        req_valid  = 1'b0;
        chk("write_no_resp", 64'(resp_valid), 64'd0);
    endtask

    task automatic do_read(input string tag, input int bank, input int word, input logic [31:0] exp);
        req_valid  = 1'b1;
        read_write = 1'b0;
        address    = {3'(bank), 10'(word)};
        data_in    = 32'hDEAD_BEEF;
        byte_en    = 4'hF;
        tick();
        req_valid  = 1'b0;
        chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
        chk(tag, 64'(dataOut), 64'(exp));
    endtask

    // Counts cycles spent with req_ready low; optionally keeps a write to
    // bank 2 word 8 pending throughout, which must be ignored.
    task automatic wait_init(input string tag, input bit poke);
        int cyc = 0;
        if (poke) begin
            req_valid  = 1'b1;
            read_write = 1'b1;
            address    = {3'd2, 10'd8};
            data_in    = 32'hCAFE_F00D;
            byte_en    = 4'hF;
        end
        while (!req_ready && cyc < 2000) begin
            cyc++;
            tick();
        end
        req_valid = 1'b0;
        chk(tag, 64'(cyc), 64'd1024);
        chk({tag, "_done"}, 64'(init_done), 64'd1);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        read_write = 1'b0;
        address    = '0;
        data_in    = '0;
        byte_en    = '0;
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_done",  64'(init_done), 64'd0);
        chk("rst_resp",  64'(resp_valid), 64'd0);
        chk("rst_dout",  64'(dataOut), 64'd0);
        reset = 1'b0;

        wait_init("init_len", 1'b1);
        do_read("b7w1023_clear", 7, 1023, 32'h0);
        do_read("b2w8_ignored", 2, 8, 32'h0);

        do_write(0, 0, 32'hA5A5_A5A5, 4'hF);
        do_read("b0w0_raw", 0, 0, 32'hA5A5_A5A5);

        do_write(1, 4, 32'h1234_5678, 4'hF);
        do_write(1, 4, 32'hFFFF_FFFF, 4'b0101);
        do_read("b1w4_bytes", 1, 4, 32'h12FF_56FF);
        do_write(1, 4, 32'h0000_0000, 4'h0);
        do_read("b1w4_be0", 1, 4, 32'h12FF_56FF);

        do_write(5, 4, 32'h6942_0632, 4'hF);
        do_write(6, 4, 32'h1839_9137, 4'hF);
        do_read("b5w4", 5, 4, 32'h6942_0632);
        do_read("b6w4", 6, 4, 32'h1839_9137);
        do_read("b4w4_clear", 4, 4, 32'h0);

        // Idle cycle: response drops, data holds.
        tick();
        chk("idle_resp", 64'(resp_valid), 64'd0);
        chk("idle_hold", 64'(dataOut), 64'd0);
        do_read("b5w4_again", 5, 4, 32'h6942_0632);
        tick();
        chk("hold_val", 64'(dataOut), 64'h6942_0632);

        // Address extremes map to distinct words.
        do_write(0, 1023, 32'h0BAD_0001, 4'hF);
        do_write(7, 0,    32'h0BAD_0002, 4'hF);
        do_read("b0w1023", 0, 1023, 32'h0BAD_0001);
        do_read("b7w0",    7, 0,    32'h0BAD_0002);
        do_read("b7w1023", 7, 1023, 32'h0);

        // Read request coincides with reset: squashed, sweep restarts.
        req_valid  = 1'b1;
        read_write = 1'b0;
        address    = {3'd5, 10'd4};
        reset      = 1'b1;
        tick();
        req_valid  = 1'b0;
        reset      = 1'b0;
        chk("rst2_resp",  64'(resp_valid), 64'd0);
        chk("rst2_dout",  64'(dataOut), 64'd0);
        chk("rst2_ready", 64'(req_ready), 64'd0);
        wait_init("init2_len", 1'b0);
        do_read("b0w0_cleared", 0, 0, 32'h0);
        do_read("b1w4_cleared", 1, 4, 32'h0);
        do_read("b5w4_cleared", 5, 4, 32'h0);
        do_read("b7w0_cleared", 7, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
